axis_adder_pipe: RTL and testbench
==================================

Name: axis_adder_pipe

Overview:
- Parametrised successor to the single-bit handshake half adder in the axis arithmetic set.
- Accepts WIDTH-bit operand pairs with carry-in and an add/subtract mode over a valid/ready handshake.
- Computes sum, carry/not-borrow and signed overflow, and queues results in a DEPTH-entry output buffer so upstream can stream while downstream stalls.
- Sits between the operand source and the matrix-multiply accumulate path.

Parameters:
- WIDTH, 8, operand and sum width in bits (>=1).
- DEPTH, 2, result buffer entries (>=1; power of two not required).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-low reset (0 = reset asserted)
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- cin_in  input  1  carry-in (add) / borrow-in (sub)
- sub_in  input  1  mode: 0 = add, 1 = subtract
- valid_in  input  1  operand beat valid
- ready_out  output  1  block can accept a beat
- sum_out  output  WIDTH  result at buffer head
- carry_out  output  1  add: carry; sub: not-borrow
- ovf_out  output  1  signed two's-complement overflow
- valid_out  output  1  result at head valid
- ready_in  input  1  downstream accepts result
- level_out  output  $clog2(DEPTH+1)  results currently buffered

Behaviour:
- Reset (rst low, asynchronous):
  - Buffer emptied; level_out=0, valid_out=0.
  - sum_out=0, carry_out=0, ovf_out=0.
  - ready_out=0.
- After release: ready_out rises on the first rising edge with rst high; all regs update synchronously thereafter.
- Accept: beat is taken on a rising edge where valid_in && ready_out. Operands, cin_in and sub_in are sampled together on that edge.
- Arithmetic, computed in the accepting cycle, WIDTH+1 bits:
  - add: {carry,sum} = a + b + cin
  - sub: {carry,sum} = a + ~b + ~cin, i.e. a - b - cin; carry=1 means no borrow
  - ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' = b (add) or ~b (sub)
- Buffer:
  - FIFO of {sum,carry,ovf}.
  - Push on accept; pop on rising edge where valid_out && ready_in.
  - Outputs are driven from registered head entry; data stays stable while valid_out && !ready_in.
- Latency:
  - Buffer empty: accept at edge N gives valid_out=1 after edge N, with result on outputs.
  - Throughput 1 beat/cycle when ready_in held high.
- ready_out:
  - Registered, = (level < DEPTH) after the edge, accounting for that edge's push and pop.
  - Buffer full with pop in the same cycle: ready_out rises after that edge; no same-cycle full-bypass.
- Simultaneous push and pop (not full): level unchanged; order preserved.
- Empty with ready_in high: no pop, no underflow; valid_out stays 0.
- Full with valid_in high: beat not accepted; upstream holds.
- Pointers wrap modulo DEPTH; level never exceeds DEPTH.
- Reset mid-stream: all buffered results discarded immediately; no output beat appears after reset release until a new accept.
- WIDTH-bit wrap: sum truncated to WIDTH; the carry bit carries the (WIDTH+1)th bit.

Decomposition:
- Package axis_arith_pkg:
  - mode constants MODE_ADD=1'b0, MODE_SUB=1'b1
  - function computing {ovf,carry,sum} for given WIDTH, shared with the future subtract/accumulate blocks
- One sub-module: axis_result_fifo, parametrised synchronous FIFO (data width, DEPTH), with level and full/empty.
- Top holds the arithmetic and handshake glue.

Test Plan:
- Add, WIDTH=8, DEPTH=2: a=0xFF, b=0x01, cin=0, ready_in=1 -> sum=0x00, carry=1, ovf=0; valid_out high one cycle after accept.
- Sub with overflow: a=0x80, b=0x01, cin=0, sub=1 -> sum=0x7F, carry=1, ovf=1. Then a=0x00, b=0x01 -> sum=0xFF, carry=0, ovf=0.
- Backpressure:
  - ready_in=0, three beats 0x01+0x01, 0x02+0x02, 0x03+0x03 offered -> level_out goes 1 then 2; ready_out=0 after second accept; third beat held.
  - Raise ready_in -> outputs 0x02, 0x04, 0x06 in order; no loss or duplication.
- Streaming: ready_in=1, valid_in=1 for 16 cycles with a=i, b=i -> 16 results 2*i, back-to-back; level_out stays <=1.
- Reset mid-stream: buffer holding 2 results, rst pulled low between edges -> valid_out, ready_out and level_out drop to 0 immediately. After release, ready_out=1 next edge and no stale result appears.
- Empty pop: ready_in=1, valid_in=0 for 5 cycles after reset -> valid_out=0, level_out=0 throughout.

Source files
------------

// File: rtl/axis_arith_pkg.sv
// Shared arithmetic helpers for the axis arithmetic blocks.
// Operands are carried at MaxWidth bits; callers pass their real width.
package axis_arith_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Widest operand any block in the set may use.
  localparam int unsigned MaxWidth = 64;

  typedef struct packed {
    logic                ovf;
    logic                carry;
    logic [MaxWidth-1:0] sum;
  } arith_res_t;

  // sub: a + ~b + ~cin, so carry reads as not-borrow; ovf is signed overflow
  // of the effective addition at bit (width-1).
  function automatic arith_res_t arith_calc(input logic [MaxWidth-1:0] a,
                                            input logic [MaxWidth-1:0] b,
                                            input logic                cin,
                                            input logic                sub,
                                            input int unsigned         width);
    logic [MaxWidth-1:0] mask;
    logic [MaxWidth-1:0] msb_mask;
    logic [MaxWidth-1:0] a_m;
    logic [MaxWidth-1:0] b_eff;
    logic [MaxWidth:0]   carry_mask;
    logic [MaxWidth:0]   total;
    logic                cin_eff;
    logic                a_msb;
    logic                b_msb;
    logic                s_msb;
    arith_res_t          res;

    mask       = '1;
    mask       = mask >> (MaxWidth - width);
    msb_mask   = {{(MaxWidth-1){1'b0}}, 1'b1} << (width - 1);
    carry_mask = {{MaxWidth{1'b0}}, 1'b1} << width;

    a_m     = a & mask;
    b_eff   = ((sub == MODE_SUB) ? ~b : b) & mask;
    cin_eff = (sub == MODE_SUB) ? ~cin : cin;
    total   = {1'b0, a_m} + {1'b0, b_eff} + {{MaxWidth{1'b0}}, cin_eff};

    res.sum   = total[MaxWidth-1:0] & mask;
    res.carry = |(total & carry_mask);

    a_msb   = |(a_m & msb_mask);
    b_msb   = |(b_eff & msb_mask);
    s_msb   = |(res.sum & msb_mask);
    res.ovf = (a_msb == b_msb) && (s_msb != a_msb);
    return res;
  endfunction

endpackage

// File: rtl/axis_result_fifo.sv
// Synchronous FIFO with occupancy level; output is the registered head entry.
// Pushes while full and pops while empty are ignored.
module axis_result_fifo #(
  parameter int unsigned DataWidth = 10,
  parameter int unsigned Depth     = 2,
  localparam int unsigned LevelW   = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic [LevelW-1:0]    level_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0]    level_q, level_d;
  logic                 push_en, pop_en;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (level_q == LevelW'(Depth));
  assign empty_o = (level_q == '0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = push_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    level_d  = level_q;
    case ({push_en, pop_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/axis_adder_pipe.sv
// Handshaked WIDTH-bit add/subtract with carry and signed overflow, results
// queued in a DEPTH-entry buffer. WIDTH must not exceed axis_arith_pkg::MaxWidth.
module axis_adder_pipe
  import axis_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             a_in,
  input  logic [WIDTH-1:0]             b_in,
  input  logic                         cin_in,
  input  logic                         sub_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  output logic [WIDTH-1:0]             sum_out,
  output logic                         carry_out,
  output logic                         ovf_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic [$clog2(DEPTH+1)-1:0]   level_out
);

  localparam int unsigned LevelW = $clog2(DEPTH + 1);
  localparam int unsigned DataW  = WIDTH + 2;

  arith_res_t        calc;
  logic [DataW-1:0]  push_data;
  logic [DataW-1:0]  head;
  logic [LevelW-1:0] level;
  logic              full, empty;
  logic              push, pop;
  logic              ready_q, ready_d;

  assign calc      = arith_calc(MaxWidth'(a_in), MaxWidth'(b_in), cin_in, sub_in, WIDTH);
  assign push_data = {calc.sum[WIDTH-1:0], calc.carry, calc.ovf};

  if (WIDTH < MaxWidth) begin : gen_sum_pad
    logic unused_sum_hi;
    assign unused_sum_hi = ^calc.sum[MaxWidth-1:WIDTH];
  end

  assign push = valid_in && ready_q;
  assign pop  = !empty && ready_in;

  // Level after this edge stays below DEPTH if we pop, or if a push still
  // leaves room; otherwise it only changes when not already full.
  always_comb begin
    ready_d = 1'b0;
    if (pop) begin
      ready_d = 1'b1;
    end else if (push) begin
      ready_d = (level < LevelW'(DEPTH - 1));
    end else begin
      ready_d = !full;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
    end
  end

  axis_result_fifo #(
    .DataWidth (DataW),
    .Depth     (DEPTH)
  ) u_result_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign ready_out = ready_q;
  assign valid_out = !empty;
  assign level_out = level;
  assign sum_out   = head[DataW-1:2];
  assign carry_out = head[1];
  assign ovf_out   = head[0];

endmodule

// File: tb/tb_axis_adder_pipe.sv
// Scoreboard bench for axis_adder_pipe: driver pushes model results on accept,
// a monitor pops and compares on every output handshake.
module tb_axis_adder_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 2;
  localparam int unsigned LW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a_in, b_in;
  logic          cin_in, sub_in, valid_in, ready_in;
  logic          ready_out, carry_out, ovf_out, valid_out;
  logic [W-1:0]  sum_out;
  logic [LW-1:0] level_out;

  int compared   = 0;
  int mismatched = 0;
  int out_count  = 0;
  bit rand_bp    = 1'b0;
  logic [W+1:0] exp_q[$];

  always #5 clk = ~clk;

  axis_adder_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin_in    (cin_in),
    .sub_in    (sub_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .sum_out   (sum_out),
    .carry_out (carry_out),
    .ovf_out   (ovf_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .level_out (level_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Integer reference: unsigned result range gives carry, signed range gives ovf.
  function automatic logic [W+1:0] model(input int unsigned a, input int unsigned b,
                                         input bit cin, input bit sub);
    longint m, la, lb, lc, r, s, sa, sb, sr;
    bit carry, ovf;
    logic [W-1:0] sum;
    m  = longint'(1) << W;
    la = a; lb = b; lc = cin;
    r  = sub ? (la - lb - lc) : (la + lb + lc);
    s  = ((r % m) + m) % m;
    carry = sub ? (r >= 0) : (r >= m);
    sa = (la >= m / 2) ? la - m : la;
    sb = (lb >= m / 2) ? lb - m : lb;
    sr = sub ? (sa - sb - lc) : (sa + sb + lc);
    ovf = (sr < -(m / 2)) || (sr >= m / 2);
    sum = W'(s);
    return {sum, carry, ovf};
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        check("output_with_empty_scoreboard", valid_out, 0);
      end else begin
        check("result", {sum_out, carry_out, ovf_out}, exp_q.pop_front());
        out_count++;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      ready_in = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_accept(input logic [W+1:0] e, output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      if (ready_out) break;
      waited++;
      if (waited > 100) begin
        check("accept_timeout", ready_out, 1);
        valid_in = 1'b0;
        return;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic send(input int unsigned a, input int unsigned b, input bit cin,
                      input bit sub, output int waited);
    a_in     = W'(a);
    b_in     = W'(b);
    cin_in   = cin;
    sub_in   = sub;
    valid_in = 1'b1;
    wait_accept(model(a, b, cin, sub), waited);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;
    a_in = '0; b_in = '0; cin_in = 0; sub_in = 0; valid_in = 0; ready_in = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("rst_valid_out", valid_out, 0);
    check("rst_ready_out", ready_out, 0);
    check("rst_level_out", level_out, 0);
    check("rst_sum_out", sum_out, 0);
    check("rst_carry_out", carry_out, 0);
    check("rst_ovf_out", ovf_out, 0);
    repeat (3) @(posedge clk);
    #1 check("ready_held_in_reset", ready_out, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check("ready_after_release", ready_out, 1);

    // Empty pop attempts
    ready_in = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("empty_valid_out", valid_out, 0);
      check("empty_level_out", level_out, 0);
    end
    @(posedge clk);
    #1;

    // Directed arithmetic
    send(8'hFF, 8'h01, 0, 0, w);
    check("latency_valid_out", valid_out, 1);
    check("add_wrap", {sum_out, carry_out, ovf_out}, {8'h00, 1'b1, 1'b0});
    send(8'h80, 8'h01, 0, 1, w);
    check("sub_ovf", {sum_out, carry_out, ovf_out}, {8'h7F, 1'b1, 1'b1});
    send(8'h00, 8'h01, 0, 1, w);
    check("sub_borrow", {sum_out, carry_out, ovf_out}, {8'hFF, 1'b0, 1'b0});
    drain();

    // Backpressure: fill, hold a third beat, then release
    base = out_count;
    ready_in = 1'b0;
    send(1, 1, 0, 0, w);
    check("bp_level_1", level_out, 1);
    send(2, 2, 0, 0, w);
    check("bp_level_2", level_out, 2);
    check("bp_ready_full", ready_out, 0);
    a_in = 8'h03; b_in = 8'h03; cin_in = 0; sub_in = 0; valid_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_held_ready", ready_out, 0);
      check("bp_held_level", level_out, 2);
    end
    ready_in = 1'b1;
    wait_accept(model(3, 3, 0, 0), w);
    drain();
    check("bp_out_count", out_count - base, 3);

    // Streaming at full rate
    base = out_count;
    for (int i = 0; i < 16; i++) begin
      send(i, i, 0, 0, w);
      check("stream_no_stall", w, 0);
      check("stream_level_le1", level_out <= 1, 1);
    end
    drain();
    check("stream_out_count", out_count - base, 16);

    // Reset mid-stream with two buffered results
    ready_in = 1'b0;
    send(5, 6, 1, 0, w);
    send(7, 8, 0, 1, w);
    check("mid_level_2", level_out, 2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid_out", valid_out, 0);
    check("mid_rst_ready_out", ready_out, 0);
    check("mid_rst_level_out", level_out, 0);
    exp_q.delete();
    ready_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check("mid_ready_after_release", ready_out, 1);
    repeat (4) begin
      @(negedge clk);
      check("mid_no_stale", valid_out, 0);
    end
    @(posedge clk);
    #1;

    // Random operands with random downstream backpressure
    base = out_count;
    rand_bp = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), w);
      check("rand_level_le_depth", level_out <= D, 1);
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2 ready_in = 1'b1;
    drain();
    check("rand_out_count", out_count - base, 80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
